event_logger: RTL and testbench

EVENT_LOGGER -- requirements
Module: event_logger

---
 rtl/event_logger_pkg.sv | 27 ++
 rtl/logger_mem.sv | 23 ++
 rtl/event_logger.sv | 93 +++++++++
 tb/tb_event_logger.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/event_logger_pkg.sv
// Shared constants and helpers for the event logger: depth default, pointer
// and count widths, and bit offsets of the fields inside a stored entry.
package event_logger_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int WIDTH_DEF = 32;
  localparam int COUNT_W   = 9;
  localparam int DROP_W    = 32;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Entry layout is {a, b, s} with s in the least-significant field
  function automatic int off_s(input int w);
    return 0;
  endfunction

  function automatic int off_b(input int w);
    return w;
  endfunction

  function automatic int off_a(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/logger_mem.sv
// Entry storage: one write port and one registered read port. A write to the
// address being read is forwarded so a fresh head is visible next cycle.
module logger_mem #(
  parameter int ENTRY_W = 96,
  parameter int DEPTH   = 16,
  parameter int AW      = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/event_logger.sv
// Show-ahead capture FIFO for monitor events with drop counting and a sticky
// overflow flag; all outputs come from registers.
module event_logger
  import event_logger_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_event,
  input  logic [WIDTH-1:0]   i_dut_ia,
  input  logic [WIDTH-1:0]   i_dut_ib,
  input  logic [WIDTH-1:0]   i_dut_os,
  input  logic               i_freeze,
  input  logic               i_pop,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_a,
  output logic [WIDTH-1:0]   o_b,
  output logic [WIDTH-1:0]   o_s,
  output logic [COUNT_W-1:0] o_count,
  output logic [DROP_W-1:0]  o_dropped,
  output logic               o_overflow
);

  localparam int PW      = ptr_w(DEPTH);
  localparam int ENTRY_W = 3 * WIDTH;
  localparam int A_OFF   = off_a(WIDTH);
  localparam int B_OFF   = off_b(WIDTH);
  localparam int S_OFF   = off_s(WIDTH);

  logic [PW-1:0]      wr_ptr, rd_ptr, rd_addr;
  logic [COUNT_W-1:0] count, count_nxt;
  logic [DROP_W-1:0]  dropped;
  logic               overflow, vld_p1;
  logic               armed, do_pop, do_push, do_drop;
  logic [ENTRY_W-1:0] entry_p1;

  always_comb begin
    armed     = i_event && !i_freeze;
    do_pop    = i_pop && (count != '0);
    // A full buffer still accepts an event when the same cycle frees a slot
    do_push   = armed && ((count < COUNT_W'(DEPTH)) || do_pop);
    do_drop   = armed && !do_push;
    count_nxt = count;
    if (do_push && !do_pop) count_nxt = count + COUNT_W'(1);
    if (do_pop && !do_push) count_nxt = count - COUNT_W'(1);
    rd_addr   = do_pop ? rd_ptr + PW'(1) : rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      vld_p1   <= 1'b0;
      dropped  <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count  <= count_nxt;
      vld_p1 <= (count_nxt != '0);
      if (do_drop) begin
        overflow <= 1'b1;
        if (dropped != '1) dropped <= dropped + DROP_W'(1);
      end
    end
  end

  logger_mem #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH),
    .AW      (PW)
  ) u_mem (
    .clk     (clk),
    .we      (do_push && !reset),
    .wr_addr (wr_ptr),
    .wr_data ({i_dut_ia, i_dut_ib, i_dut_os}),
    .rd_addr (rd_addr),
    .rd_data (entry_p1)
  );

  // ---- stage p1: registered head entry, zeroed while empty
  assign o_valid    = vld_p1;
  assign o_a        = vld_p1 ? entry_p1[A_OFF +: WIDTH] : '0;
  assign o_b        = vld_p1 ? entry_p1[B_OFF +: WIDTH] : '0;
  assign o_s        = vld_p1 ? entry_p1[S_OFF +: WIDTH] : '0;
  assign o_count    = count;
  assign o_dropped  = dropped;
  assign o_overflow = overflow;

endmodule

// File: tb/tb_event_logger.sv
// Directed bench for event_logger: stimulus queues expected entries, a
// monitor compares the head whenever the host pops a valid entry.
module tb_event_logger;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_event, i_freeze, i_pop;
  logic [31:0] i_dut_ia, i_dut_ib, i_dut_os;
  logic        o_valid, o_overflow;
  logic [31:0] o_a, o_b, o_s, o_dropped;
  logic [8:0]  o_count;

  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt    = 0;
  logic [95:0] exp_q[$];

  event_logger #(.WIDTH(32), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .i_event(i_event),
    .i_dut_ia(i_dut_ia), .i_dut_ib(i_dut_ib), .i_dut_os(i_dut_os),
    .i_freeze(i_freeze), .i_pop(i_pop), .o_valid(o_valid),
    .o_a(o_a), .o_b(o_b), .o_s(o_s), .o_count(o_count),
    .o_dropped(o_dropped), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: a host pop of a valid head must return the oldest expected entry
  always @(negedge clk) begin
    if (reset === 1'b0 && i_pop === 1'b1 && o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", {o_a, o_b, o_s}, 96'h0);
      end else begin
        chk("pop_entry", {o_a, o_b, o_s}, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic rst, input logic ev, input logic frz, input logic pop,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    logic acc, pp;
    reset = rst; i_event = ev; i_freeze = frz; i_pop = pop;
    i_dut_ia = a; i_dut_ib = b; i_dut_os = s;
    pp  = !rst && pop && (m_cnt > 0);
    acc = !rst && ev && !frz && ((m_cnt < 16) || pp);
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (acc) exp_q.push_back({a, b, s});
      m_cnt = m_cnt + int'(acc) - int'(pp);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; i_event = 1'b0; i_freeze = 1'b0; i_pop = 1'b0;
    i_dut_ia = '0; i_dut_ib = '0; i_dut_os = '0;
  endtask

  task automatic ev(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, a, b, s);
  endtask

  task automatic pop1();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic rst1();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; i_event = 1'b0; i_freeze = 1'b0; i_pop = 1'b0;
    i_dut_ia = '0; i_dut_ib = '0; i_dut_os = '0;
    rst1();
    rst1();
    chk("rst_valid", 96'(o_valid), 96'h0);
    chk("rst_count", 96'(o_count), 96'h0);
    chk("rst_dropped", 96'(o_dropped), 96'h0);
    chk("rst_overflow", 96'(o_overflow), 96'h0);
    chk("rst_fields", {o_a, o_b, o_s}, 96'h0);

    // Single event then pop
    ev(32'h1, 32'h2, 32'h4);
    chk("one_valid", 96'(o_valid), 96'h1);
    chk("one_s", 96'(o_s), 96'h4);
    chk("one_ab", {32'h0, o_a, o_b}, {32'h0, 32'h1, 32'h2});
    chk("one_count", 96'(o_count), 96'h1);
    pop1();
    chk("one_pop_valid", 96'(o_valid), 96'h0);
    chk("one_pop_a", 96'(o_a), 96'h0);
    chk("one_pop_count", 96'(o_count), 96'h0);

    // 17 events into a 16-deep buffer, then drain
    for (int i = 0; i < 17; i++) ev(32'(i), 32'(i + 100), 32'(i + 200));
    chk("full_count", 96'(o_count), 96'd16);
    chk("full_dropped", 96'(o_dropped), 96'd1);
    chk("full_overflow", 96'(o_overflow), 96'h1);
    chk("full_head", {o_a, o_b, o_s}, {32'd0, 32'd100, 32'd200});
    for (int i = 0; i < 16; i++) pop1();
    chk("drain_count", 96'(o_count), 96'h0);
    chk("drain_valid", 96'(o_valid), 96'h0);
    chk("drain_overflow_sticky", 96'(o_overflow), 96'h1);

    // Full buffer: event and pop together
    for (int i = 0; i < 16; i++) ev(32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i));
    chk("fill_count", 96'(o_count), 96'd16);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h1FF, 32'h2FF, 32'h3FF);
    chk("fullpp_count", 96'(o_count), 96'd16);
    chk("fullpp_dropped", 96'(o_dropped), 96'd1);
    chk("fullpp_head", {o_a, o_b, o_s}, {32'h101, 32'h201, 32'h301});
    for (int i = 0; i < 16; i++) pop1();
    chk("fullpp_drain", 96'(o_count), 96'h0);

    // Empty buffer: event and pop together keep the event
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'hAA, 32'hBB, 32'hCC);
    chk("emptypp_count", 96'(o_count), 96'd1);
    chk("emptypp_entry", {o_a, o_b, o_s}, {32'hAA, 32'hBB, 32'hCC});
    pop1();
    chk("emptypp_drain", 96'(o_valid), 96'h0);

    // Freeze blocks captures and drop counting
    rst1();
    chk("rst2_overflow", 96'(o_overflow), 96'h0);
    chk("rst2_dropped", 96'(o_dropped), 96'h0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'(i), 32'h5, 32'h6);
    chk("frz_count", 96'(o_count), 96'h0);
    chk("frz_dropped", 96'(o_dropped), 96'h0);
    pop1();
    chk("pop_empty_count", 96'(o_count), 96'h0);
    chk("pop_empty_valid", 96'(o_valid), 96'h0);
    chk("pop_empty_fields", {o_a, o_b, o_s}, 96'h0);
    for (int i = 0; i < 16; i++) ev(32'h40 + 32'(i), 32'h50, 32'h60);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 32'hF00D);
    chk("frz_full_dropped", 96'(o_dropped), 96'h0);
    chk("frz_pop_count", 96'(o_count), 96'd15);
    chk("frz_pop_head", 96'(o_a), 96'h41);

    // Reset mid-stream with event and pop
    rst1();
    for (int i = 0; i < 8; i++) ev(32'h70 + 32'(i), 32'h80, 32'h90);
    chk("eight_count", 96'(o_count), 96'd8);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h123, 32'h456, 32'h789);
    chk("midrst_valid", 96'(o_valid), 96'h0);
    chk("midrst_count", 96'(o_count), 96'h0);
    chk("midrst_fields", {o_a, o_b, o_s}, 96'h0);
    chk("midrst_flags", {o_dropped, 31'h0, o_overflow}, 96'h0);
    ev(32'h5A, 32'h6B, 32'h7C);
    chk("post_rst_entry", {o_a, o_b, o_s}, {32'h5A, 32'h6B, 32'h7C});
    pop1();
    chk("scoreboard_empty", 96'(exp_q.size()), 96'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
